// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - data memory stage: word RAM plus MMIO cycle counter and byte TX FIFO
//
// Purpose: serves loads and stores from a single-cycle core. Addresses with bit 31
// clear hit a word RAM; addresses with bit 31 set hit a four-register MMIO page
// (CYCLE, TXDATA, TXSTATUS, reserved). Bytes pushed to TXDATA drain through a
// valid/ready stream.
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   dmem_wren           one-cycle store strobe
//   dmem_addr           byte address (bit 31 selects MMIO, [3:2] selects register)
//   dmem_data_in        store data
//   dmem_data_out       combinational load data
//   tx_data, tx_valid   FIFO head byte (0 when empty) and non-empty flag
//   tx_ready            sink accepts tx_data this cycle
module dmem_mmio #(
  parameter int RAM_DEPTH  = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_wren,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_data_in,
  output logic [31:0] dmem_data_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(RAM_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]   ram_q [RAM_DEPTH];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [31:0]   cycle_q, cycle_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic [AW-1:0] ram_idx;
  logic          is_mmio;
  logic [1:0]    reg_sel;
  logic          ram_wr, cyc_wr, txd_wr, sts_wr;
  logic          fifo_full, fifo_empty;
  logic          pop, push, push_drop;
  logic [7:0]    count8;
  logic [31:0]   status_word;
  logic          unused_bits;

  assign ram_idx = dmem_addr[AW+1:2];
  assign is_mmio = dmem_addr[31];
  assign reg_sel = dmem_addr[3:2];
  assign unused_bits = ^{dmem_addr[30:AW+2], dmem_addr[1:0]};

  assign ram_wr = dmem_wren & ~is_mmio;
  assign cyc_wr = dmem_wren & is_mmio & (reg_sel == 2'd0);
  assign txd_wr = dmem_wren & is_mmio & (reg_sel == 2'd1);
  assign sts_wr = dmem_wren & is_mmio & (reg_sel == 2'd2);

  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign tx_valid   = ~fifo_empty;
  assign tx_data    = tx_valid ? fifo_q[rd_ptr_q] : 8'h00;

  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign pop       = tx_valid & tx_ready;
  assign push      = txd_wr & (~fifo_full | pop);
  assign push_drop = txd_wr & fifo_full & ~pop;

  always_comb begin
    count8 = '0;
    count8[CW-1:0] = count_q;
  end

  assign status_word = {16'b0, count8, 5'b0, ovf_q, fifo_full, fifo_empty};

  always_comb begin
    dmem_data_out = 32'h0;
    if (!is_mmio) begin
      dmem_data_out = ram_q[ram_idx];
    end else begin
      case (reg_sel)
        2'd0:    dmem_data_out = cycle_q;
        2'd2:    dmem_data_out = status_word;
        default: dmem_data_out = 32'h0;
      endcase
    end
  end

  always_comb begin
    cycle_d  = cyc_wr ? dmem_data_in : cycle_q + 32'd1;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Overflow set takes priority over a simultaneous clear.
    ovf_d = ovf_q;
    if (sts_wr && dmem_data_in[2]) ovf_d = 1'b0;
    if (push_drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q  <= 32'h0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cycle_q  <= cycle_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage arrays carry no reset; the FIFO is emptied by clearing its count and pointers.
  always_ff @(posedge clk) begin
    if (ram_wr) ram_q[ram_idx] <= dmem_data_in;
    if (push)   fifo_q[wr_ptr_q] <= dmem_data_in[7:0];
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb/tb_dmem_mmio.sv - self-checking bench for dmem_mmio with a behavioural reference model
module tb_dmem_mmio;

  localparam int RAM_DEPTH  = 256;
  localparam int FIFO_DEPTH = 8;
  localparam logic [31:0] A_CYC = 32'h8000_0000;
  localparam logic [31:0] A_TXD = 32'h8000_0004;
  localparam logic [31:0] A_STS = 32'h8000_0008;
  localparam logic [31:0] A_RSV = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic        dmem_wren;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_data_in;
  logic [31:0] dmem_data_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  dmem_mmio #(.RAM_DEPTH(RAM_DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .dmem_wren(dmem_wren), .dmem_addr(dmem_addr),
    .dmem_data_in(dmem_data_in), .dmem_data_out(dmem_data_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  logic [31:0] m_ram [RAM_DEPTH];
  bit          m_ram_ok [RAM_DEPTH];
  logic [31:0] m_cycle;
  logic [7:0]  m_q [$];
  bit          m_ovf;
  logic [31:0] last_dout;
  logic [7:0]  last_tx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ram_slot(input logic [31:0] a);
    return int'((a / 4) % RAM_DEPTH);
  endfunction

  function automatic logic [31:0] m_status();
    int n = m_q.size();
    return (n << 8) | (m_ovf ? 4 : 0) | (n == FIFO_DEPTH ? 2 : 0) | (n == 0 ? 1 : 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31] == 1'b0) return m_ram[ram_slot(a)];
    case ((a / 4) % 4)
      0: return m_cycle;
      2: return m_status();
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_known(input logic [31:0] a);
    return a[31] || m_ram_ok[ram_slot(a)];
  endfunction

  task automatic m_update(input logic w, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    bit popped = (m_q.size() > 0) && rdy;
    int r = int'((a / 4) % 4);
    if (popped) void'(m_q.pop_front());
    if (w && a[31] && r == 0) m_cycle = d;
    else m_cycle = m_cycle + 32'd1;
    if (w && !a[31]) begin
      m_ram[ram_slot(a)] = d;
      m_ram_ok[ram_slot(a)] = 1'b1;
    end
    if (w && a[31] && r == 1) begin
      if (m_q.size() < FIFO_DEPTH) m_q.push_back(d[7:0]);
      else m_ovf = 1'b1;
    end
    if (w && a[31] && r == 2 && d[2]) m_ovf = 1'b0;
  endtask

  task automatic m_reset();
    m_q.delete();
    m_cycle = 32'h0;
    m_ovf = 1'b0;
  endtask

  // Drive one cycle of inputs, compare combinational outputs with the model, then clock.
  task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    dmem_wren = w; dmem_addr = a; dmem_data_in = d; tx_ready = rdy;
    #1;
    last_dout = dmem_data_out;
    last_tx = tx_data;
    if (m_known(a)) check("dout", dmem_data_out, m_read(a));
    check("tx_valid", {31'b0, tx_valid}, {31'b0, m_q.size() != 0});
    check("tx_data", {24'b0, tx_data}, {24'b0, (m_q.size() != 0) ? m_q[0] : 8'h00});
    @(posedge clk);
    m_update(w, a, d, rdy);
    #1;
  endtask

  initial begin
    reset = 1'b1; dmem_wren = 1'b0; dmem_addr = A_CYC; dmem_data_in = 32'h0; tx_ready = 1'b0;
    for (int i = 0; i < RAM_DEPTH; i++) m_ram_ok[i] = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_cycle", dmem_data_out, 32'h0);
    dmem_addr = A_STS; #1;
    check("rst_status", dmem_data_out, 32'h1);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'b0, tx_data}, 32'h0);
    reset = 1'b0;

    // RAM store, load, alias and unaligned offset
    step(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    step(1'b0, 32'h10, 32'h0, 1'b0);
    check("ram_load", last_dout, 32'hDEAD_BEEF);
    step(1'b0, 32'h10 + RAM_DEPTH * 4, 32'h0, 1'b0);
    check("ram_alias", last_dout, 32'hDEAD_BEEF);
    step(1'b0, 32'h13, 32'h0, 1'b0);
    check("ram_byte_off", last_dout, 32'hDEAD_BEEF);

    // CYCLE counter free-running after a reset, then wrap
    reset = 1'b1; #1; reset = 1'b0; m_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, A_CYC, 32'h0, 1'b0);
      check("cycle_seq", last_dout, 32'(i));
    end
    step(1'b1, A_CYC, 32'hFFFF_FFFE, 1'b0);
    step(1'b0, A_CYC, 32'h0, 1'b0);
    check("cycle_fffe", last_dout, 32'hFFFF_FFFE);
    step(1'b0, A_CYC, 32'h0, 1'b0);
    check("cycle_ffff", last_dout, 32'hFFFF_FFFF);
    step(1'b0, A_CYC, 32'h0, 1'b0);
    check("cycle_wrap", last_dout, 32'h0);

    // FIFO basic push and drain
    step(1'b1, A_TXD, 32'h41, 1'b0);
    check("push_no_fallthru", {31'b0, tx_valid}, 32'h1);
    step(1'b1, A_TXD, 32'h42, 1'b0);
    step(1'b0, A_STS, 32'h0, 1'b0);
    check("status_cnt2", last_dout, 32'h0000_0200);
    check("head_41", {24'b0, last_tx}, 32'h41);
    step(1'b0, A_TXD, 32'h0, 1'b1);
    check("txdata_reads0", last_dout, 32'h0);
    check("drain_41", {24'b0, last_tx}, 32'h41);
    step(1'b0, A_STS, 32'h0, 1'b1);
    check("drain_42", {24'b0, last_tx}, 32'h42);
    step(1'b0, A_STS, 32'h0, 1'b0);
    check("status_empty", last_dout, 32'h1);

    // Overflow: FIFO_DEPTH+1 pushes, last byte dropped, W1C clears ovf
    for (int i = 0; i <= FIFO_DEPTH; i++) step(1'b1, A_TXD, 32'h10 + 32'(i), 1'b0);
    step(1'b0, A_STS, 32'h0, 1'b0);
    check("status_ovf", last_dout, 32'h0000_0806);
    step(1'b1, A_RSV, 32'h4, 1'b0);
    step(1'b1, A_STS, 32'h4, 1'b0);
    step(1'b0, A_STS, 32'h0, 1'b0);
    check("status_ovf_clr", last_dout, 32'h0000_0802);

    // Full push+pop on the same edge keeps count and order across pointer wrap
    for (int i = 0; i < 5; i++) begin
      step(1'b1, A_TXD, 32'h60 + 32'(i), 1'b1);
      check("fullpp_head", {24'b0, last_tx}, 32'h10 + 32'(i));
      step(1'b0, A_STS, 32'h0, 1'b0);
      check("fullpp_status", last_dout, 32'h0000_0802);
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      step(1'b0, A_STS, 32'h0, 1'b1);
      check("wrap_order", {24'b0, last_tx}, (i < 3) ? 32'h15 + 32'(i) : 32'h60 + 32'(i - 3));
    end

    // Randomized traffic against the model; RAM words 0..15 stay untouched
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] a, d;
      logic w;
      d = $urandom;
      w = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0)
        a = {1'b0, 21'($urandom), 8'($urandom_range(16, 255)), 2'($urandom)};
      else begin
        a = {1'b1, 27'($urandom), 2'($urandom_range(0, 3)), 2'($urandom)};
        if (a[3:2] == 2'd0 && $urandom_range(0, 7) != 0) w = 1'b0;
      end
      step(w, a, d, 1'($urandom));
    end

    // Reset asserted mid-drain
    m_reset();
    reset = 1'b1; #1; reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, A_TXD, 32'hA0 + 32'(i), 1'b0);
    step(1'b0, A_CYC, 32'h0, 1'b1);
    dmem_addr = A_CYC;
    reset = 1'b1;
    #1;
    check("rst_mid_valid", {31'b0, tx_valid}, 32'h0);
    check("rst_mid_data", {24'b0, tx_data}, 32'h0);
    check("rst_mid_cycle", dmem_data_out, 32'h0);
    dmem_addr = A_STS; #1;
    check("rst_mid_status", dmem_data_out, 32'h1);
    m_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    step(1'b0, 32'h10, 32'h0, 1'b1);
    check("ram_after_rst", last_dout, 32'hDEAD_BEEF);
    step(1'b0, A_CYC, 32'h0, 1'b1);
    check("cycle_after_rst", last_dout, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
